// File: rtl/load_store_unit.sv
// Load/store unit: one memory instruction at a time over a word-wide req/gnt/rsp bus.
// Misaligned accesses are split into two beats; load data is aligned and extended.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  Start_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    input  logic [ADDR_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Done_o,
    output logic                  Stall_o,
    output logic                  BusReq_o,
    output logic                  BusWe_o,
    output logic [ADDR_WIDTH-1:0] BusAddr_o,
    output logic [3:0]            BusBe_o,
    output logic [DATA_WIDTH-1:0] BusWData_o,
    input  logic                  BusGnt_i,
    input  logic                  BusRValid_i,
    input  logic [DATA_WIDTH-1:0] BusRData_i
);

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, zext_q, split_q;
    logic [2:0]              size_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, beat0_q, rdata_q;

    logic [2:0]              size_in;
    logic [3:0]              mask;
    logic [7:0]              be_pair;
    logic [2*DATA_WIDTH-1:0] wd_pair;
    logic [DATA_WIDTH-1:0]   rsp_b0, rsp_b1, rd_shift, rd_ext;
    logic                    load_done;

    always_comb begin
        unique case (MemType_i)
            2'b01:   size_in = 3'd1;
            2'b10:   size_in = 3'd2;
            default: size_in = 3'd4;
        endcase
    end

    always_comb begin
        unique case (size_q)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    // Shifting across a two-word window yields both beats' lanes at once:
    // the low half is beat 0, the high half is beat 1.
    assign be_pair = {4'b0000, mask} << off_q;
    assign wd_pair = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};

    // The final beat's data is taken straight from the bus so the result is
    // registered on the same edge that enters DONE.
    assign rsp_b0   = (state_q == RSP0) ? BusRData_i : beat0_q;
    assign rsp_b1   = (state_q == RSP1) ? BusRData_i : '0;
    assign rd_shift = DATA_WIDTH'({rsp_b1, rsp_b0} >> {off_q, 3'b000});

    always_comb begin
        unique case (size_q)
            3'd1:    rd_ext = {{(DATA_WIDTH-8){rd_shift[7] & ~zext_q}}, rd_shift[7:0]};
            3'd2:    rd_ext = {{(DATA_WIDTH-16){rd_shift[15] & ~zext_q}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    assign load_done = !we_q && BusRValid_i &&
                       ((state_q == RSP0 && !split_q) || state_q == RSP1);

    always_comb begin
        state_d    = state_q;
        Stall_o    = 1'b0;
        Done_o     = 1'b0;
        BusReq_o   = 1'b0;
        BusWe_o    = 1'b0;
        BusAddr_o  = '0;
        BusBe_o    = '0;
        BusWData_o = '0;
        unique case (state_q)
            IDLE: begin
                Stall_o = Start_i;
                if (Start_i) state_d = REQ0;
            end
            REQ0: begin
                Stall_o    = 1'b1;
                BusReq_o   = 1'b1;
                BusWe_o    = we_q;
                BusAddr_o  = waddr_q;
                BusBe_o    = be_pair[3:0];
                BusWData_o = wd_pair[DATA_WIDTH-1:0];
                if (BusGnt_i) begin
                    if (!we_q)       state_d = RSP0;
                    else if (split_q) state_d = REQ1;
                    else             state_d = DONE;
                end
            end
            RSP0: begin
                Stall_o = 1'b1;
                if (BusRValid_i) state_d = split_q ? REQ1 : DONE;
            end
            REQ1: begin
                Stall_o    = 1'b1;
                BusReq_o   = 1'b1;
                BusWe_o    = we_q;
                BusAddr_o  = waddr_q + ADDR_WIDTH'(4);
                BusBe_o    = be_pair[7:4];
                BusWData_o = wd_pair[2*DATA_WIDTH-1:DATA_WIDTH];
                if (BusGnt_i) state_d = we_q ? DONE : RSP1;
            end
            RSP1: begin
                Stall_o = 1'b1;
                if (BusRValid_i) state_d = DONE;
            end
            DONE: begin
                Done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            zext_q  <= 1'b0;
            split_q <= 1'b0;
            size_q  <= 3'd4;
            off_q   <= 2'd0;
            waddr_q <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && Start_i) begin
                we_q    <= MemWrite_i;
                zext_q  <= MemSign_i;
                size_q  <= size_in;
                off_q   <= Addr_i[1:0];
                split_q <= ({2'b00, Addr_i[1:0]} + {1'b0, size_in}) > 4'd4;
                waddr_q <= {Addr_i[ADDR_WIDTH-1:2], 2'b00};
                wdata_q <= WriteData_i;
            end
            if (state_q == RSP0 && BusRValid_i) beat0_q <= BusRData_i;
            if (load_done) rdata_q <= rd_ext;
        end
    end

    assign ReadData_o = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes one memory instruction at a time on behalf of the core, consuming the decoder's MemWrite/MemType/MemSign fields and the ALU byte address.
- Drives a word-wide request/grant/response data bus.
- Handles byte, halfword and word accesses, including misaligned ones split into two bus beats.
- Stalls the pipeline until the access completes, then returns the aligned, extended load data.

Parameters:
- DATA_WIDTH, 32, data/bus width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width; all address arithmetic is modulo 2^ADDR_WIDTH.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- Start_i  in  1  memory instruction valid; sampled only in IDLE
- MemWrite_i  in  1  1=store, 0=load
- MemType_i  in  2  00=word, 01=byte, 10=half, 11 treated as word
- MemSign_i  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores
- Addr_i  in  ADDR_WIDTH  byte address
- WriteData_i  in  DATA_WIDTH  store data, right-justified
- ReadData_o  out  DATA_WIDTH  extended load result
- Done_o  out  1  one-cycle completion pulse
- Stall_o  out  1  pipeline hold
- BusReq_o  out  1  bus request valid
- BusWe_o  out  1  bus write
- BusAddr_o  out  ADDR_WIDTH  word-aligned address; bits [1:0] always 0
- BusBe_o  out  4  byte enables; bit n = lane n (bits 8n+7:8n)
- BusWData_o  out  DATA_WIDTH  lane-aligned write data
- BusGnt_i  in  1  request accepted this cycle
- BusRValid_i  in  1  read data valid
- BusRData_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (async, rst_n_i low): state=IDLE. All outputs 0, including ReadData_o. Any in-flight beat is abandoned; BusReq_o drops immediately.
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE:
  - When Start_i=1, register the command, off=Addr[1:0], size (1/2/4 bytes) and split=(off+size>4); go to REQ0.
  - Stall_o=Start_i (combinational).
- Stall_o=1 in REQ0, RSP0, REQ1 and RSP1; Stall_o=0 in IDLE (without Start_i) and in DONE.
- REQ0:
  - Outputs: BusReq_o=1, BusAddr_o={Addr[31:2],2'b00}, BusWe_o=MemWrite.
  - BusBe_o = mask(size)<<off, truncated to 4 bits.
  - BusWData_o = WriteData<<(8*off).
  - Outputs are held stable until a cycle with BusGnt_i=1.
  - On grant: load → RSP0; store → REQ1 if split, else DONE.
- RSP0: wait for BusRValid_i; capture beat0 = BusRData_i; go to REQ1 if split, else DONE.
- REQ1:
  - BusAddr_o = word address + 4 (wraps 0xFFFFFFFC→0x00000000).
  - BusBe_o = mask(size)>>(4-off).
  - BusWData_o = WriteData>>(8*(4-off)).
  - On grant: load → RSP1; store → DONE.
- RSP1: on BusRValid_i, capture beat1 and go to DONE.
- DONE:
  - Done_o=1 for exactly one cycle; next state is IDLE; Start_i is ignored in this cycle.
  - Loads: ReadData_o is registered on entry to DONE as ({beat1,beat0}>>(8*off)) truncated to size, zero-extended if MemSign=1, else sign-extended from bit 8*size-1.
  - ReadData_o holds its value until the next load completes. Stores leave ReadData_o unchanged.
- BusReq_o=0 in IDLE, RSP0, RSP1 and DONE.
- BusRValid_i outside RSP0/RSP1 is ignored. BusGnt_i outside REQ0/REQ1 is ignored.
- Minimum latency:
  - Aligned store with immediate grant: Start in IDLE at cycle 0 → REQ0 in cycle 1 → DONE in cycle 2.
  - Aligned load with same-cycle grant and RValid one cycle later: DONE in cycle 3.
  - Each extra beat adds the same cost.

Test Plan:
- Aligned load, word: lw Addr=0x100, BusRData=0xDEADBEEF.
  → Beat at 0x100 with BE=1111; ReadData_o=0xDEADBEEF; Done_o pulses once; Stall_o high from Start through RSP0.
- Byte loads: lb Addr=0x203, BusRData=0x80xxxxxx → ReadData_o=0xFFFFFF80. Same access as lbu (MemSign=1) → 0x00000080. Both issue BE=1000.
- Misaligned store: sw Addr=0x12, WriteData=0x11223344.
  → Beat0: addr 0x10, BE=1100, WData=0x3344xxxx.
  → Beat1: addr 0x14, BE=0011, WData=0xxxxx1122.
  → Done_o after beat1 grant.
- Misaligned halfword with wrap: lh Addr=0xFFFFFFFF, beat0 data=0xAB000000, beat1 data=0x000000CD.
  → Beats at 0xFFFFFFFC (BE=1000) then 0x00000000 (BE=0001); ReadData_o=0xFFFFCDAB.
- Grant stall: hold BusGnt_i=0 for 5 cycles during REQ0.
  → BusAddr_o/BusBe_o/BusWData_o/BusReq_o stable throughout; exactly one grant-acknowledged beat.
- Reset mid-operation: assert rst_n_i low while in RSP0.
  → BusReq_o, Stall_o, Done_o and ReadData_o go to 0 asynchronously; after release a fresh lw completes normally with no stale beat.
